mmio_periph_responder: RTL and testbench

//  Responder side of the CPU data-memory bus: decodes MEM-stage load/store cycles in the peripheral window.

---
 rtl/periph_pkg.sv | 28 ++
 rtl/mmio_periph_responder_seg7_scanner.sv | 54 +++++
 rtl/mmio_periph_responder.sv | 133 +++++++++++++
 tb/tb_mmio_periph_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_pkg.sv
// Shared definitions for the MMIO peripheral responder: register byte offsets,
// timer control bit positions and the active-low 7-segment hex decode table.
package periph_pkg;

    localparam logic [31:0] WINDOW_BYTES = 32'h0000_0018;

    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LED     = 5'h0C;
    localparam logic [4:0] OFF_DIGI    = 5'h10;
    localparam logic [4:0] OFF_SYSTICK = 5'h14;

    localparam int TCON_RUN  = 0;
    localparam int TCON_IE   = 1;
    localparam int TCON_STAT = 2;

    // Segment bit order {dp,g,f,e,d,c,b,a}, active-low, dp always off.
    localparam logic [7:0] SEG7_HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [7:0] hex2seg(input logic [3:0] nibble);
        return SEG7_HEX[nibble];
    endfunction

endpackage

// File: rtl/mmio_periph_responder_seg7_scanner.sv
// Hardware 7-segment scanner: walks the four digits of a 16-bit hex value,
// dwelling SCAN_DIV clock cycles on each. Only built when DIGI_SCAN_EN is defined.
module seg7_scanner
    import periph_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_i,
    output logic [11:0] digi_o
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       nibble;
    logic [3:0]       an;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= 2'd0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_comb begin
        nibble = value_i[3:0];
        case (idx_q)
            2'd0: nibble = value_i[3:0];
            2'd1: nibble = value_i[7:4];
            2'd2: nibble = value_i[11:8];
            2'd3: nibble = value_i[15:12];
            default: nibble = value_i[3:0];
        endcase
        an     = ~(4'b0001 << idx_q);
        digi_o = {an, hex2seg(nibble)};
    end

endmodule

// File: rtl/mmio_periph_responder.sv
// Data-bus responder for the timer/LED/7-seg/systick window at BASE_ADDR.
// Define DIGI_SCAN_EN to build the hardware digit scanner (16-bit DIGI value).
module mmio_periph_responder
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          SCAN_DIV  = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        hit,
    output logic        irq,
    output logic [7:0]  led,
    output logic [11:0] digi
);

`ifdef DIGI_SCAN_EN
    localparam int DIGI_W = 16;
`else
    localparam int DIGI_W = 12;
`endif

    logic [31:0]       off;
    logic [4:0]        regOff;
    logic              wrEn;
    logic              overflow;
    logic              ovfSet;

    logic [31:0]       th_q, th_d;
    logic [31:0]       tl_q, tl_d;
    logic [2:0]        tcon_q, tcon_d;
    logic [7:0]        led_q, led_d;
    logic [DIGI_W-1:0] digi_q, digi_d;
    logic [31:0]       systick_q, systick_d;
    logic              irq_q, irq_d;

    // Offset arithmetic keeps the decode valid for any word-aligned base.
    assign off    = Address - BASE_ADDR;
    assign hit    = (off < WINDOW_BYTES);
    assign regOff = {off[4:2], 2'b00};
    assign wrEn   = MemWrite & hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digi_d    = digi_q;
        systick_d = systick_q + 32'd1;
        irq_d     = tcon_q[TCON_IE] & tcon_q[TCON_STAT];

        overflow = tcon_q[TCON_RUN] && (tl_q == 32'hFFFF_FFFF);
        ovfSet   = overflow & tcon_q[TCON_IE];

        if (tcon_q[TCON_RUN]) begin
            tl_d = overflow ? th_q : (tl_q + 32'd1);
        end
        tcon_d[TCON_STAT] = tcon_q[TCON_STAT] | ovfSet;

        // Software stores override the timer; a hardware overflow still sets status.
        if (wrEn) begin
            case (regOff)
                OFF_TH:   th_d = Write_data;
                OFF_TL:   tl_d = Write_data;
                OFF_TCON: begin
                    tcon_d[TCON_RUN]  = Write_data[TCON_RUN];
                    tcon_d[TCON_IE]   = Write_data[TCON_IE];
                    tcon_d[TCON_STAT] = Write_data[TCON_STAT] | ovfSet;
                end
                OFF_LED:  led_d  = Write_data[7:0];
                OFF_DIGI: digi_d = Write_data[DIGI_W-1:0];
                default:  ;
            endcase
        end
    end

    always_comb begin
        Read_data = 32'h0;
        if (MemRead && hit) begin
            case (regOff)
                OFF_TH:      Read_data = th_q;
                OFF_TL:      Read_data = tl_q;
                OFF_TCON:    Read_data = 32'(tcon_q);
                OFF_LED:     Read_data = 32'(led_q);
                OFF_DIGI:    Read_data = 32'(digi_q);
                OFF_SYSTICK: Read_data = systick_q;
                default:     Read_data = 32'h0;
            endcase
        end
    end

    assign irq = irq_q;
    assign led = led_q;

`ifdef DIGI_SCAN_EN
    seg7_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk     (clk),
        .reset   (reset),
        .value_i (digi_q),
        .digi_o  (digi)
    );
`else
    assign digi = digi_q;
`endif

endmodule

// File: tb/tb_mmio_periph_responder.sv
// Self-checking bench for mmio_periph_responder: directed scenarios plus random
// bus traffic, all compared against a cycle-level behavioural model of the register map.
module tb_mmio_periph_responder;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          SDIV = 4;

    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Read_data;
    logic        hit;
    logic        irq;
    logic [7:0]  led;
    logic [11:0] digi;

    mmio_periph_responder #(
        .BASE_ADDR (BASE),
        .SCAN_DIV  (SDIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .hit        (hit),
        .irq        (irq),
        .led        (led),
        .digi       (digi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state of the peripheral as software sees it.
    logic [31:0] mTh, mTl, mSys;
    logic [2:0]  mTcon;
    logic [7:0]  mLed;
    logic [15:0] mDigi;
    logic        mIrq;
    int          mCyc;

    // Values observed on the most recent applyStimulus cycle.
    logic [31:0] obsRd;
    logic        obsHit;
    logic        obsIrq;
    logic [7:0]  obsLed;
    logic [11:0] obsDigi;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic bit inWin(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd24);
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        int word;
        if (!inWin(a)) return 32'h0;
        word = int'((a - BASE) >> 2);
        case (word)
            0: return mTh;
            1: return mTl;
            2: return {29'h0, mTcon};
            3: return {24'h0, mLed};
`ifdef DIGI_SCAN_EN
            4: return {16'h0, mDigi};
`else
            4: return {20'h0, mDigi[11:0]};
`endif
            5: return mSys;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [11:0] modelDigi();
`ifdef DIGI_SCAN_EN
        int idx;
        logic [3:0] an;
        logic [3:0] nib;
        idx = (mCyc / SDIV) % 4;
        nib = 4'((mDigi >> (idx * 4)) & 16'hF);
        an = 4'b1111;
        an[idx] = 1'b0;
        return {an, SEG_TAB[nib]};
`else
        return mDigi[11:0];
`endif
    endfunction

    task automatic modelReset();
        mTh = '0; mTl = '0; mSys = '0; mTcon = '0;
        mLed = '0; mDigi = '0; mIrq = 1'b0; mCyc = 0;
    endtask

    task automatic modelStep(input logic [31:0] addr, input logic [31:0] wdata, input logic wr);
        logic        ovf;
        logic        ovfSet;
        logic [31:0] nTl;
        logic [2:0]  nTcon;
        logic        nIrq;
        int          word;
        ovf    = mTcon[0] && (mTl == 32'hFFFF_FFFF);
        ovfSet = ovf && mTcon[1];
        nIrq   = mTcon[1] && mTcon[2];
        nTl    = mTl;
        if (mTcon[0]) nTl = ovf ? mTh : mTl + 32'd1;
        nTcon = mTcon;
        if (ovfSet) nTcon[2] = 1'b1;
        if (wr && inWin(addr)) begin
            word = int'((addr - BASE) >> 2);
            case (word)
                0: mTh = wdata;
                1: nTl = wdata;
                2: nTcon = {wdata[2] | ovfSet, wdata[1:0]};
                3: mLed = wdata[7:0];
                4: mDigi = wdata[15:0];
                default: ;
            endcase
        end
        mTl   = nTl;
        mTcon = nTcon;
        mIrq  = nIrq;
        mSys  = mSys + 32'd1;
        mCyc++;
    endtask

    // One bus cycle: drive, check every output mid-cycle, then advance model at the edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic rd, input logic wr);
        Address    = addr;
        Write_data = wdata;
        MemRead    = rd;
        MemWrite   = wr;
        #3;
        obsRd   = Read_data;
        obsHit  = hit;
        obsIrq  = irq;
        obsLed  = led;
        obsDigi = digi;
        checkOutput("hit",  32'(obsHit),  32'(inWin(addr)));
        checkOutput("rdata", obsRd, rd ? modelRead(addr) : 32'h0);
        checkOutput("irq",  32'(obsIrq),  32'(mIrq));
        checkOutput("led",  32'(obsLed),  32'(mLed));
        checkOutput("digi", 32'(obsDigi), 32'(modelDigi()));
        @(posedge clk);
        modelStep(addr, wdata, wr);
        #1;
    endtask

    task automatic doReset();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic wr32(input logic [31:0] off, input logic [31:0] d);
        applyStimulus(BASE + off, d, 1'b0, 1'b1);
    endtask

    task automatic rd32(input logic [31:0] off);
        applyStimulus(BASE + off, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        Address = '0; Write_data = '0; MemRead = 1'b0; MemWrite = 1'b0;
        reset = 1'b1;
        doReset();

        // Reset values; systick first since it starts counting immediately.
        rd32(32'h14); checkOutput("rst_systick", obsRd, 32'h0);
`ifdef DIGI_SCAN_EN
        checkOutput("rst_digi", 32'(obsDigi), 32'h0000_0EC0);
`else
        checkOutput("rst_digi", 32'(obsDigi), 32'h0);
`endif
        for (int i = 0; i < 5; i++) begin
            rd32(32'(i * 4));
            checkOutput("rst_reg", obsRd, 32'h0);
        end
        applyStimulus(32'h4000_0014, 32'h0, 1'b0, 1'b0); checkOutput("hit_14", 32'(obsHit), 32'h1);
        applyStimulus(32'h4000_0018, 32'h0, 1'b1, 1'b0); checkOutput("hit_18", 32'(obsHit), 32'h0);
        applyStimulus(32'h1000_0000, 32'h0, 1'b1, 1'b0); checkOutput("hit_off", 32'(obsHit), 32'h0);

        // Timer overflow, reload and interrupt.
        wr32(32'h00, 32'hFFFF_FFF0);
        wr32(32'h04, 32'hFFFF_FFFE);
        wr32(32'h08, 32'h3);
        rd32(32'h04); checkOutput("tl_fffe", obsRd, 32'hFFFF_FFFE);
        rd32(32'h04); checkOutput("tl_ffff", obsRd, 32'hFFFF_FFFF);
        rd32(32'h04); checkOutput("tl_reload", obsRd, 32'hFFFF_FFF0);
        checkOutput("irq_lag", 32'(obsIrq), 32'h0);
        rd32(32'h08); checkOutput("tcon_stat", obsRd, 32'h7);
        checkOutput("irq_set", 32'(obsIrq), 32'h1);

        // Status clear drops irq one cycle later.
        wr32(32'h08, 32'h3);
        rd32(32'h08); checkOutput("tcon_clr", obsRd, 32'h3);
        checkOutput("irq_hold", 32'(obsIrq), 32'h1);
        rd32(32'h08); checkOutput("irq_clr", 32'(obsIrq), 32'h0);

        // Clear coinciding with overflow: TH=TL=all-ones overflows every cycle.
        wr32(32'h00, 32'hFFFF_FFFF);
        wr32(32'h04, 32'hFFFF_FFFF);
        rd32(32'h08);
        wr32(32'h08, 32'h3);
        rd32(32'h08); checkOutput("stat_wins", obsRd, 32'h7);
        wr32(32'h08, 32'h0);
        wr32(32'h08, 32'h0);
        rd32(32'h08); checkOutput("tcon_off", obsRd, 32'h0);

        // Software TL write wins over increment.
        wr32(32'h08, 32'h1);
        wr32(32'h04, 32'h5);
        rd32(32'h04); checkOutput("tl_wr5", obsRd, 32'h5);
        rd32(32'h04); checkOutput("tl_inc6", obsRd, 32'h6);

        // LED register and out-of-window accesses.
        wr32(32'h0C, 32'h0000_01A5);
        rd32(32'h0C); checkOutput("led_a5", 32'(obsLed), 32'hA5);
        checkOutput("led_rd", obsRd, 32'hA5);
        wr32(32'h20, 32'hFFFF_FFFF);
        rd32(32'h20); checkOutput("led_keep", 32'(obsLed), 32'hA5);
        checkOutput("rd_oow", obsRd, 32'h0);

        // 7-segment output.
`ifdef DIGI_SCAN_EN
        wr32(32'h10, 32'h0000_1234);
        for (int i = 0; i < 20; i++) applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
        rd32(32'h10); checkOutput("digi_rd", obsRd, 32'h1234);
`else
        wr32(32'h10, 32'h0000_07F9);
        rd32(32'h10); checkOutput("digi_7f9", 32'(obsDigi), 32'h7F9);
        checkOutput("digi_rd", obsRd, 32'h7F9);
`endif

        // Reset mid-count discards everything.
        wr32(32'h08, 32'h1);
        rd32(32'h04);
        doReset();
        rd32(32'h04); checkOutput("rst_tl", obsRd, 32'h0);
        rd32(32'h0C); checkOutput("rst_led", obsRd, 32'h0);

        // Random bus traffic, biased toward the window and timer wrap points.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) a = $urandom();
            else          a = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) d = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            else                           d = $urandom();
            if (a - BASE >= 32'h8 && a - BASE < 32'hC && $urandom_range(0, 1) == 1)
                d = 32'($urandom_range(0, 7));
            applyStimulus(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
